// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory; reads return 2 cycles after request.
// Optional DM_ARBITER_LOCK_EN adds lock0/lock1 so the current owner can keep re-granting itself.
`ifndef INSTR_WORD_WIDTH
  `define INSTR_WORD_WIDTH 16
`endif
`ifndef DATA_WIDTH
  `define DATA_WIDTH 32
`endif

module dm_arbiter #(
  parameter int ADDRESS_WIDTH = `INSTR_WORD_WIDTH,
  parameter int DATA_WIDTH    = `DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
`ifdef DM_ARBITER_LOCK_EN
  input  logic                     lock0,
  input  logic                     lock1,
`endif
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic [DATA_WIDTH-1:0]    rdata0,
  output logic [DATA_WIDTH-1:0]    rdata1,
  output logic                     mem_wr,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     busy
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_ACC  = 1'b1;

  logic                     state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     we_q, we_d;
  logic                     last_q, last_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rdata0_q, rdata1_q;
  logic                     rvalid0_q, rvalid1_q;
  logic                     acc, hold0, hold1, elig0, elig1, win;

  assign acc = (state_q == ST_ACC);

`ifdef DM_ARBITER_LOCK_EN
  assign hold0 = acc & ~owner_q & req0 & lock0;
  assign hold1 = acc &  owner_q & req1 & lock1;
`else
  assign hold0 = 1'b0;
  assign hold1 = 1'b0;
`endif

  // The owner's req is still high during its own grant cycle, so mask it unless locked.
  assign elig0 = req0 & ~(acc & ~owner_q & ~hold0);
  assign elig1 = req1 & ~(acc &  owner_q & ~hold1);

  always_comb begin
    state_d = ST_IDLE;
    owner_d = owner_q;
    we_d    = we_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (hold0 | hold1)      win = owner_q;
    else if (elig0 & elig1) win = ~last_q;
    else                    win = elig1;
    if (elig0 | elig1) begin
      state_d = ST_ACC;
      owner_d = win;
      last_d  = win;
      we_d    = win ? we1 : we0;
      addr_d  = win ? addr1 : addr0;
      wdata_d = win ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rvalid0_q <= acc & ~we_q & ~owner_q;
      rvalid1_q <= acc & ~we_q &  owner_q;
      if (acc & ~we_q & ~owner_q) rdata0_q <= mem_rdata;
      if (acc & ~we_q &  owner_q) rdata1_q <= mem_rdata;
    end
  end

  assign gnt0      = acc & ~owner_q & ~rst;
  assign gnt1      = acc &  owner_q & ~rst;
  assign mem_wr    = acc & we_q & ~rst;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign busy      = acc;

endmodule
